// File: rtl/ber_checker.sv
// rtl/ber_checker.sv - PRBS9 bit-error-rate checker with latency search and lock FSM
module ber_checker #(
  parameter logic [8:0] SEED     = 9'h1AA,
  parameter int         NB_INPUT = 8,
  parameter int         WIN      = 511,
  parameter int         LOCK_THR = 0,
  parameter int         LOSS_THR = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       i_valid,
  input  logic                       i_enable,
  input  logic                       i_clear,
  input  logic signed [NB_INPUT-1:0] i_sample,
  output logic                       o_locked,
  output logic [8:0]                 o_latency,
  output logic [63:0]                o_bit_count,
  output logic [63:0]                o_error_count,
  output logic                       o_ber_zero
);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t       state;
  state_t       state_n;
  logic [8:0]   prbs;
  logic [510:0] hist;
  logic [9:0]   sym_cnt;
  logic [9:0]   win_err;

  logic         sym;
  logic         rx_bit;
  logic [511:0] taps;
  logic         ref_bit;
  logic         mismatch;
  logic         last;
  logic [10:0]  win_total;
  logic [8:0]   lat_n;
  logic [63:0]  bits_n;
  logic [63:0]  errs_n;

  // Symbol decode, reference tap selection and window bookkeeping.
  // taps[0] is the current generator output g(k); taps[L] is g(k-L).
  always_comb begin
    sym       = i_valid & i_enable;
    rx_bit    = (i_sample < 0);
    taps      = {hist, prbs[8]};
    ref_bit   = taps[o_latency];
    mismatch  = rx_bit ^ ref_bit;
    last      = (sym_cnt == 10'(WIN - 1));
    win_total = {1'b0, win_err} + {10'd0, mismatch};
  end

  // Next-state for the lock FSM and the saturating LOCKED-only counters.
  // The window verdict includes the last symbol's own mismatch.
  always_comb begin
    state_n = state;
    lat_n   = o_latency;
    bits_n  = o_bit_count;
    errs_n  = o_error_count;
    if (sym) begin
      if (state == LOCKED) begin
        if (!(&o_bit_count)) bits_n = o_bit_count + 64'd1;
        if (mismatch && !(&o_error_count)) errs_n = o_error_count + 64'd1;
      end
      if (last) begin
        case (state)
          SEARCH: begin
            if (win_total <= 11'(LOCK_THR)) state_n = LOCKED;
            else lat_n = o_latency + 9'd1;
          end
          LOCKED: begin
            if (win_total > 11'(LOSS_THR)) state_n = SEARCH;
          end
          default: state_n = SEARCH;
        endcase
      end
    end
    // Clear beats a coincident symbol: that symbol is dropped from the counts.
    if (i_enable && i_clear) begin
      bits_n = 64'd0;
      errs_n = 64'd0;
    end
  end

  // Reference generator, history line and window counters advance per symbol.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prbs    <= SEED;
      hist    <= '0;
      sym_cnt <= '0;
      win_err <= '0;
    end else if (sym) begin
      prbs <= {prbs[7:0], prbs[8] ^ prbs[4]};
      hist <= {hist[509:0], prbs[8]};
      if (last) begin
        sym_cnt <= '0;
        win_err <= '0;
      end else begin
        sym_cnt <= sym_cnt + 10'd1;
        win_err <= win_total[9:0];
      end
    end
  end

  // Lock FSM state and all registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= SEARCH;
      o_locked      <= 1'b0;
      o_latency     <= 9'd0;
      o_bit_count   <= 64'd0;
      o_error_count <= 64'd0;
      o_ber_zero    <= 1'b0;
    end else begin
      state         <= state_n;
      o_locked      <= (state_n == LOCKED);
      o_latency     <= lat_n;
      o_bit_count   <= bits_n;
      o_error_count <= errs_n;
      o_ber_zero    <= (state_n == LOCKED) && (errs_n == 64'd0);
    end
  end

endmodule

// File: tb/tb_ber_checker.sv
// tb/tb_ber_checker.sv - scoreboard bench for ber_checker
module tb_ber_checker;

  localparam int W     = 32;
  localparam int DELAY = 37;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              i_valid = 1'b0;
  logic              i_enable = 1'b1;
  logic              i_clear = 1'b0;
  logic signed [7:0] i_sample = 8'sd0;
  logic              o_locked;
  logic [8:0]        o_latency;
  logic [63:0]       o_bit_count;
  logic [63:0]       o_error_count;
  logic              o_ber_zero;
  logic [138:0]      obs;

  typedef struct {
    string        name;
    logic [138:0] v;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n = 0;
  logic [8:0] tx_s = 9'h1AA;
  bit   tx_ring[512];
  bit   inv = 1'b0;

  ber_checker #(.SEED(9'h1AA), .NB_INPUT(8), .WIN(W), .LOCK_THR(0), .LOSS_THR(8)) dut (
    .clock(clock), .reset(reset), .i_valid(i_valid), .i_enable(i_enable),
    .i_clear(i_clear), .i_sample(i_sample), .o_locked(o_locked), .o_latency(o_latency),
    .o_bit_count(o_bit_count), .o_error_count(o_error_count), .o_ber_zero(o_ber_zero)
  );

  assign obs = {o_locked, o_latency, o_bit_count, o_error_count, o_ber_zero};

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    n    = 0;
    tx_s = 9'h1AA;
    inv  = 1'b0;
  endtask

  // One symbol of the delayed loopback stream, optionally flipped / with clear.
  task automatic send(input bit flip, input bit clr);
    bit txb, b;
    txb = tx_s[8];
    tx_ring[n % 512] = txb;
    tx_s = {tx_s[7:0], tx_s[8] ^ tx_s[4]};
    b = ((n >= DELAY) ? tx_ring[(n - DELAY) % 512] : 1'b0) ^ inv ^ flip;
    @(negedge clock);
    i_valid  = 1'b1;
    i_enable = 1'b1;
    i_clear  = clr;
    i_sample = b ? -8'sd64 : 8'sd64;
    @(posedge clock);
    #1;
    i_valid = 1'b0;
    i_clear = 1'b0;
    n++;
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    sb.push_back('{"reset_hold", 139'd0});
    e = sb.pop_front(); n_chk++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, obs, e.v); end
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    sb.push_back('{"reset_idle", 139'd0});
    e = sb.pop_front(); n_chk++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, obs, e.v); end
  endtask

  task automatic test_lock(input string tag);
    for (int i = 0; i < 38 * W; i++) begin
      if (n + 1 == W)          sb.push_back('{{tag, "_lat_step"}, {1'b0, 9'd1, 64'd0, 64'd0, 1'b0}});
      if (n + 1 == 38 * W - 1) sb.push_back('{{tag, "_pre_lock"}, {1'b0, 9'd37, 64'd0, 64'd0, 1'b0}});
      if (n + 1 == 38 * W)     sb.push_back('{{tag, "_lock"}, {1'b1, 9'd37, 64'd0, 64'd0, 1'b1}});
      send(1'b0, 1'b0);
      if (sb.size() != 0) begin
        e = sb.pop_front(); n_chk++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, obs, e.v); end
      end
    end
  endtask

  task automatic test_sparse_errors();
    for (int i = 0; i < 10000; i++) begin
      if (i == 998)  sb.push_back('{"sparse_clean", {1'b1, 9'd37, 64'd999, 64'd0, 1'b1}});
      if (i == 999)  sb.push_back('{"sparse_first", {1'b1, 9'd37, 64'd1000, 64'd1, 1'b0}});
      if (i == 9999) sb.push_back('{"sparse_total", {1'b1, 9'd37, 64'd10000, 64'd10, 1'b0}});
      send(i % 1000 == 999, 1'b0);
      if (sb.size() != 0) begin
        e = sb.pop_front(); n_chk++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, obs, e.v); end
      end
    end
  endtask

  task automatic test_clear_enable();
    sb.push_back('{"clear", {1'b1, 9'd37, 64'd0, 64'd0, 1'b1}});
    send(1'b0, 1'b1);
    e = sb.pop_front(); n_chk++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, obs, e.v); end
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      i_valid  = 1'b1;
      i_enable = 1'b0;
      i_sample = 8'($urandom);
      @(posedge clock);
      #1;
    end
    i_valid  = 1'b0;
    i_enable = 1'b1;
    sb.push_back('{"enable_hold", {1'b1, 9'd37, 64'd0, 64'd0, 1'b1}});
    e = sb.pop_front(); n_chk++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, obs, e.v); end
    for (int i = 0; i < 5; i++) begin
      if (i == 4) sb.push_back('{"enable_resume", {1'b1, 9'd37, 64'd5, 64'd0, 1'b1}});
      send(1'b0, 1'b0);
    end
    e = sb.pop_front(); n_chk++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, obs, e.v); end
  endtask

  task automatic test_loss_of_lock();
    logic [63:0] bits;
    bits = 64'd5;
    while (n % W != 0) begin
      send(1'b0, 1'b0);
      bits++;
    end
    inv = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (i == W - 2) sb.push_back('{"loss_pending", {1'b1, 9'd37, bits + 64'(W - 1), 64'(W - 1), 1'b0}});
      if (i == W - 1) sb.push_back('{"loss_drop", {1'b0, 9'd37, bits + 64'(W), 64'(W), 1'b0}});
      send(1'b0, 1'b0);
      if (sb.size() != 0) begin
        e = sb.pop_front(); n_chk++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, obs, e.v); end
      end
    end
    for (int i = 0; i < W; i++) send(1'b0, 1'b0);
    sb.push_back('{"loss_resume", {1'b0, 9'd38, bits + 64'(W), 64'(W), 1'b0}});
    e = sb.pop_front(); n_chk++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, obs, e.v); end
  endtask

  task automatic test_inverted_wrap();
    pulse_reset();
    inv = 1'b1;
    for (int i = 0; i < 512 * W; i++) begin
      if (n + 1 == 256 * W) sb.push_back('{"inv_mid", {1'b0, 9'd256, 64'd0, 64'd0, 1'b0}});
      if (n + 1 == 511 * W) sb.push_back('{"inv_max", {1'b0, 9'd511, 64'd0, 64'd0, 1'b0}});
      if (n + 1 == 512 * W) sb.push_back('{"inv_wrap", {1'b0, 9'd0, 64'd0, 64'd0, 1'b0}});
      send(1'b0, 1'b0);
      if (sb.size() != 0) begin
        e = sb.pop_front(); n_chk++;
        if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, obs, e.v); end
      end
    end
  endtask

  task automatic test_async_reset();
    pulse_reset();
    test_lock("prereset");
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    sb.push_back('{"async_reset", 139'd0});
    e = sb.pop_front(); n_chk++;
    if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h required %h", e.name, obs, e.v); end
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    test_lock("relock");
  endtask

  initial begin
    test_reset();
    test_lock("lock");
    test_sparse_errors();
    test_clear_enable();
    test_loss_of_lock();
    test_inverted_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ber_checker.md
BER_CHECKER -- requirements
Module: ber_checker

Interface
REQ-001 Parameter SEED, default 'h1AA: PRBS9 seed of the local reference generator; equals the TX generator seed.
REQ-002 Parameter NB_INPUT, default 8: width of the received sample.
REQ-003 Parameter WIN, default 511: symbols per evaluation window, legal range 2..1023.
REQ-004 Parameter LOCK_THR, default 0: maximum window errors that still permit lock in SEARCH.
REQ-005 Parameter LOSS_THR, default 64: window errors above this value drop lock in LOCKED.
REQ-006 clock  input  1  system clock; all state changes on the rising edge.
REQ-007 reset  input  1  reset, asynchronous, active-high.
REQ-008 i_valid  input  1  one-cycle symbol strobe, one per baud.
REQ-009 i_enable  input  1  RX enable; when low, all internal state and outputs hold.
REQ-010 i_clear  input  1  synchronous clear of o_bit_count and o_error_count; lock is kept.
REQ-011 i_sample  input  NB_INPUT  signed received sample at the chosen sampling offset.
REQ-012 o_locked  output  1  high while the state is LOCKED.
REQ-013 o_latency  output  9  selected reference delay in symbols, 0..511.
REQ-014 o_bit_count  output  64  bits compared while LOCKED.
REQ-015 o_error_count  output  64  mismatches while LOCKED.
REQ-016 o_ber_zero  output  1  o_locked AND o_error_count==0.

Function
REQ-017 A symbol event is i_valid=1 AND i_enable=1; no state changes on any other cycle.
REQ-018 Bit decision: rx_bit = MSB of i_sample, so a negative sample gives 1 and zero or positive gives 0.
REQ-019 Local PRBS9: state s[8:0]; output g = s[8]; on each symbol event s <= {s[7:0], s[8]^s[4]}.
REQ-020 History: a 511-bit shift register holds g(k-1)..g(k-511); it shifts in g(k) on each symbol event.
REQ-021 Reference tap: o_latency=L compares rx_bit(k) with g(k-L); L=0 uses the current g(k).
REQ-022 Window: symbol counter 0..WIN-1 and 10-bit window-error counter; both clear after the last symbol of each window.
REQ-023 Window evaluation uses the error count including the last symbol's mismatch.
REQ-024 FSM states: SEARCH (reset state) and LOCKED.
REQ-025 SEARCH, at window end: if errors <= LOCK_THR, go to LOCKED with o_latency held; otherwise o_latency <= o_latency+1, wrapping 511 to 0.
REQ-026 LOCKED, on each symbol event: o_bit_count += 1 and o_error_count += mismatch.
REQ-027 LOCKED, at window end: if errors > LOSS_THR, go to SEARCH with o_latency unchanged; counts hold.
REQ-028 Counts advance only in LOCKED; the symbol whose window end causes the transition into LOCKED is not counted.
REQ-029 Both 64-bit counters saturate at all-ones.
REQ-030 i_clear zeroes both counts on the next edge; it wins over a coincident symbol event, which is not counted.
REQ-031 All outputs are registered; o_locked and o_latency update on the edge that evaluates the window.
REQ-032 i_enable low mid-window freezes the window position; counting resumes on re-enable.

Reset
REQ-033 On reset=1, asynchronously: state SEARCH, s=SEED, history all 0, window counters 0, o_latency 0, o_locked 0, o_bit_count 0, o_error_count 0, o_ber_zero 0.
REQ-034 Reset mid-operation, including mid-window or while LOCKED, discards all progress; the search restarts at latency 0 after release.

Verification
REQ-035 Delayed loopback: error-free TX PRBS9 (same SEED) delayed 37 symbols feeds i_sample with bit 1 as negative -> o_locked rises after 38*511 symbol events, o_latency=37, o_error_count=0, o_ber_zero=1.
REQ-036 Sparse errors: after lock, flip one bit every 1000 symbols for 10000 symbols -> o_error_count=10, o_bit_count=10000, o_locked stays 1, o_ber_zero=0.
REQ-037 Inverted stream: all bits flipped from reset -> o_locked never rises; o_latency reaches 511 then wraps to 0 after 512 windows; counts stay 0.
REQ-038 Loss of lock: after lock, switch to the inverted stream -> o_locked falls at the first full window end; counts freeze; the search resumes from the held latency.
REQ-039 Clear and enable: i_clear coincident with i_valid while locked gives both counts 0 next cycle; i_enable=0 for 100 valids leaves counts and o_latency unchanged.
REQ-040 Async reset: assert reset while locked between clock edges -> all outputs take reset values immediately; after release the lock sequence of REQ-035 repeats.
